// File: rtl/tempo_beat_if.sv
// Tempo beat generator bus: timebase tick, BPM request and beat/status outputs.
//   tp_i         timebase tick, one clk wide
//   bpm_i        requested tempo (unsigned BPM), qualified by bpm_valid_i
//   bpm_valid_i  one-clk strobe
//   busy_o       divider running
//   period_o     current beat period in tp_i ticks
//   beat_o       LED drive
//   beat_pulse_o one-clk strobe at start of each beat
interface tempo_beat_if;
  logic        tp_i;
  logic [7:0]  bpm_i;
  logic        bpm_valid_i;
  logic        busy_o;
  logic [23:0] period_o;
  logic        beat_o;
  logic        beat_pulse_o;

  modport master (
    output tp_i, bpm_i, bpm_valid_i,
    input  busy_o, period_o, beat_o, beat_pulse_o
  );

  modport slave (
    input  tp_i, bpm_i, bpm_valid_i,
    output busy_o, period_o, beat_o, beat_pulse_o
  );
endinterface

// File: rtl/tempo_beat_gen.sv
// Turns a BPM value into a periodic beat: LED drive plus one-clk beat strobe.
// A restoring divider computes ticks-per-beat = TPM / bpm on every accepted
// BPM update; the beat counter then runs on the shared tp_i timebase.
//   clk_i  system clock
//   rst_i  asynchronous, active-high reset
//   bus    tempo_beat_if slave (tp_i, bpm_i, bpm_valid_i in; busy_o,
//          period_o, beat_o, beat_pulse_o out; all outputs registered)
module tempo_beat_gen #(
  parameter int unsigned PULSE_PER_NS = 5120,
  parameter int unsigned BPM_MIN      = 30,
  parameter int unsigned BPM_MAX      = 250,
  parameter int unsigned LED_ON_NS    = 100_000_000
) (
  input  logic         clk_i,
  input  logic         rst_i,
  tempo_beat_if.slave  bus
);
  localparam longint unsigned TPM_L = 64'd60_000_000_000 / longint'(PULSE_PER_NS);
  localparam logic [23:0] TPM       = 24'(TPM_L);
  localparam logic [23:0] LED_TICKS = 24'(LED_ON_NS / PULSE_PER_NS);
  localparam logic [7:0]  BPM_LO    = 8'(BPM_MIN);
  localparam logic [7:0]  BPM_HI    = 8'(BPM_MAX);
  localparam logic [4:0]  DIV_ITERS = 5'd24;

  typedef enum logic [1:0] {S_IDLE, S_DIV, S_RUN} state_t;

  state_t      r_state, w_state_n;
  logic [23:0] r_cnt, w_cnt_n;
  logic [23:0] r_dq, w_dq_n;        // dividend shifts out, quotient shifts in
  logic [7:0]  r_rem, w_rem_n;
  logic [7:0]  r_bpm, w_bpm_n;
  logic [4:0]  r_iter, w_iter_n;
  logic [23:0] r_period, w_period_n;
  logic        r_busy, w_busy_n;
  logic        r_beat, w_beat_n;
  logic        r_pulse, w_pulse_n;

  logic [7:0]  w_bpm_clamped;
  logic [8:0]  w_partial;
  logic        w_ge;
  logic [7:0]  w_diff;

  // Clamp requested tempo into [BPM_MIN, BPM_MAX]
  always_comb begin
    w_bpm_clamped = bus.bpm_i;
    if (bus.bpm_i < BPM_LO)      w_bpm_clamped = BPM_LO;
    else if (bus.bpm_i > BPM_HI) w_bpm_clamped = BPM_HI;
  end

  // One restoring-division step; remainder < bpm so the difference fits 8 bits
  assign w_partial = {r_rem, r_dq[23]};
  assign w_ge      = (w_partial >= {1'b0, r_bpm});
  assign w_diff    = 8'(w_partial - {1'b0, r_bpm});

  // Next-state and output logic
  always_comb begin
    w_state_n  = r_state;
    w_cnt_n    = r_cnt;
    w_dq_n     = r_dq;
    w_rem_n    = r_rem;
    w_bpm_n    = r_bpm;
    w_iter_n   = r_iter;
    w_period_n = r_period;
    w_pulse_n  = 1'b0;

    case (r_state)
      S_IDLE, S_RUN: begin
        // A new tempo takes priority over a coincident tick
        if (bus.bpm_valid_i) begin
          w_state_n = S_DIV;
          w_bpm_n   = w_bpm_clamped;
          w_dq_n    = TPM;
          w_rem_n   = 8'd0;
          w_iter_n  = 5'd0;
        end else if (r_state == S_RUN && bus.tp_i) begin
          if (r_cnt == r_period - 24'd1) begin
            w_cnt_n   = 24'd0;
            w_pulse_n = 1'b1;
          end else begin
            w_cnt_n = r_cnt + 24'd1;
          end
        end
      end
      S_DIV: begin
        if (r_iter == DIV_ITERS) begin
          w_period_n = r_dq;
          w_cnt_n    = 24'd0;
          w_state_n  = S_RUN;
          w_pulse_n  = 1'b1;
        end else begin
          w_dq_n   = {r_dq[22:0], w_ge};
          w_rem_n  = w_ge ? w_diff : w_partial[7:0];
          w_iter_n = r_iter + 5'd1;
        end
      end
      default: w_state_n = S_IDLE;
    endcase

    w_busy_n = (w_state_n == S_DIV);
    w_beat_n = (w_state_n == S_RUN) && (w_cnt_n < LED_TICKS);
  end

  // State and output registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state  <= S_IDLE;
      r_cnt    <= 24'd0;
      r_dq     <= 24'd0;
      r_rem    <= 8'd0;
      r_bpm    <= 8'd0;
      r_iter   <= 5'd0;
      r_period <= 24'd0;
      r_busy   <= 1'b0;
      r_beat   <= 1'b0;
      r_pulse  <= 1'b0;
    end else begin
      r_state  <= w_state_n;
      r_cnt    <= w_cnt_n;
      r_dq     <= w_dq_n;
      r_rem    <= w_rem_n;
      r_bpm    <= w_bpm_n;
      r_iter   <= w_iter_n;
      r_period <= w_period_n;
      r_busy   <= w_busy_n;
      r_beat   <= w_beat_n;
      r_pulse  <= w_pulse_n;
    end
  end

  assign bus.busy_o       = r_busy;
  assign bus.period_o     = r_period;
  assign bus.beat_o       = r_beat;
  assign bus.beat_pulse_o = r_pulse;
endmodule
